// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests, prefetch FIFO, redirect flush/drain.
// Optional misaligned-redirect trap enabled with `define IFU_MISALIGN_CHK_EN.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        if_id_write,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        instr_valid,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        fetch_fault
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [31:0]        r_fetch_pc;
    logic [31:0]        r_rsp_pc;
    logic [CNT_W-1:0]   r_outs_cnt;
    logic [CNT_W-1:0]   w_outs_nxt;
    logic [CNT_W-1:0]   r_drop_cnt;
    logic [CNT_W-1:0]   w_drop_nxt;
    logic [CNT_W-1:0]   r_fifo_cnt;
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [31:0]        r_fifo_pc   [FIFO_DEPTH];
    logic [31:0]        r_fifo_data [FIFO_DEPTH];

    logic        w_fault;
    logic        w_rsp_ok;
    logic        w_credit;
    logic        w_req_valid;
    logic        w_req_fire;
    logic        w_instr_valid;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_target;

    // Low address bits are always dropped; the optional check only flags them.
    assign w_target = redirect_pc & ~32'h0000_0003;

`ifdef IFU_MISALIGN_CHK_EN
    logic r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fault <= 1'b0;
        end else if (redirect_valid) begin
            r_fault <= |redirect_pc[1:0];
        end
    end

    assign w_fault = r_fault;
`else
    assign w_fault = 1'b0;
`endif

    assign fetch_fault = w_fault;

    // Responses arriving with nothing outstanding are ignored.
    assign w_rsp_ok      = imem_rsp_valid && (r_outs_cnt != '0);
    assign w_credit      = ({1'b0, r_outs_cnt} + {1'b0, r_fifo_cnt}) < DEPTH_C;
    assign w_req_valid   = (r_state == S_RUN) && w_credit && !redirect_valid && !w_fault;
    assign w_req_fire    = w_req_valid && imem_req_ready;
    assign w_instr_valid = (r_fifo_cnt != '0) && !redirect_valid && !w_fault;
    assign w_push        = (r_state == S_RUN) && w_rsp_ok && !redirect_valid;
    assign w_pop         = w_instr_valid && if_id_write;

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign instr_valid    = w_instr_valid;
    assign instr_out      = w_instr_valid ? r_fifo_data[r_rd_ptr] : 32'h0;
    assign pc_out         = w_instr_valid ? r_fifo_pc[r_rd_ptr]   : 32'h0;

    always_comb begin
        w_state_nxt = r_state;
        w_outs_nxt  = r_outs_cnt;
        w_drop_nxt  = r_drop_cnt;
        if (redirect_valid) begin
            // Everything still in flight must be discarded before refetching.
            w_outs_nxt  = r_outs_cnt - CNT_W'(w_rsp_ok);
            w_drop_nxt  = w_outs_nxt;
            w_state_nxt = (w_outs_nxt != '0) ? S_DRAIN : S_RUN;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nxt = S_RUN;
                end
                S_RUN: begin
                    w_outs_nxt = r_outs_cnt + CNT_W'(w_req_fire) - CNT_W'(w_rsp_ok);
                end
                S_DRAIN: begin
                    if (w_rsp_ok) begin
                        w_outs_nxt = r_outs_cnt - CNT_W'(1);
                        w_drop_nxt = r_drop_cnt - CNT_W'(1);
                    end
                    if (w_drop_nxt == '0) begin
                        w_state_nxt = S_RUN;
                    end
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_outs_cnt <= '0;
            r_drop_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_outs_cnt <= w_outs_nxt;
            r_drop_cnt <= w_drop_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (redirect_valid) begin
            r_fetch_pc <= w_target;
            r_rsp_pc   <= w_target;
            r_fifo_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            if (w_req_fire) begin
                r_fetch_pc <= r_fetch_pc + 32'd4;
            end
            if (w_push) begin
                r_rsp_pc <= r_rsp_pc + 32'd4;
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    // Storage carries no reset; validity comes from r_fifo_cnt.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
            r_fifo_data[r_wr_ptr] <= imem_rsp_data;
        end
    end

`ifndef SYNTHESIS
    a_rsp_without_req: assert property (
        @(posedge clk) disable iff (!rst_n) imem_rsp_valid |-> (r_outs_cnt != '0)
    );
`endif

endmodule
